traffic_request_latch: RTL and testbench
========================================

TRAFFIC_REQUEST_LATCH -- requirements
Module: traffic_request_latch

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of consecutive stable clocks (10 ms at 100 MHz) needed to accept a button level change.
REQ-002 CLK100MHZ  input  1  sole clock, 100 MHz; every flop SHALL be clocked on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 BTNR, BTNL, BTNU, BTND  input  1 each  raw, asynchronous push-buttons, active-high.
REQ-005 serve_east_west, serve_north_south  input  1 each  one-clock pulses from the traffic-light state machine when it grants that road's request.
REQ-006 request_east_west, request_north_south  output  1 each  registered, held pending-request flags.
REQ-007 Ports present only when REQUEST_AGING_EN is defined:
- one_second_tick  input  1  one-clock tick, once per second.
- request_age_ew, request_age_ns  output  4 each  seconds the request has been pending.

Function
REQ-008 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-009 Each button SHALL have a debounce counter and a debounced level:
- counter cleared whenever the synchronized input equals the debounced level;
- otherwise counter increments;
- on reaching DEBOUNCE_CYCLES-1, the debounced level takes the synchronized value and the counter clears.
REQ-010 A change lasting fewer than DEBOUNCE_CYCLES consecutive clocks SHALL leave the debounced level unchanged.
REQ-011 A 0->1 transition of a debounced level SHALL produce exactly one one-clock press pulse. A continuously held button SHALL produce only that one pulse.
REQ-012 Press pulses SHALL be combined per road:
- BTNR or BTNL -> east_west press;
- BTNU or BTND -> north_south press.
REQ-013 Request flag behaviour, per road:
- set on a press;
- cleared on a serve pulse;
- otherwise holds.
REQ-014 If a press and a serve occur in the same clock, the request SHALL remain 1 (set wins).
REQ-015 A serve pulse while the request is 0 SHALL have no effect.
REQ-016 Press-to-request latency: after a raw edge held stable, the request SHALL rise no earlier than DEBOUNCE_CYCLES and no later than DEBOUNCE_CYCLES+4 clocks after the edge.
REQ-017 The two roads SHALL operate independently. Simultaneous presses on both roads SHALL set both requests in the same clock.

Reset
REQ-018 While reset_n=0, the following SHALL be 0 asynchronously:
- synchronizer flops;
- debounced levels;
- counters;
- requests;
- ages.
REQ-019 Reset release SHALL take effect at the first rising edge after deassertion. A button already held at release SHALL produce a press after debounce.
REQ-020 Reset asserted mid-debounce or mid-request SHALL discard all pending state. No request SHALL survive reset.

Configuration
REQ-021 With macro REQUEST_AGING_EN defined, each road's 4-bit age SHALL behave as follows:
- reset to 0 on the clock a request sets from 0;
- increments on one_second_tick while the request is 1;
- saturates at 15;
- clears to 0 with the request;
- set-wins collisions (REQ-014) reload 0.
REQ-022 Without REQUEST_AGING_EN, the tick and age ports and the age logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-023 Package traffic_pkg SHALL hold:
- DEBOUNCE_DEFAULT=1_000_000;
- AGE_W=4;
- AGE_MAX=15;
- typedef road_t {ROAD_EW, ROAD_NS}.
REQ-024 Sub-module btn_debounce (synchronizer, debounce counter, rising-edge pulse), parameterized by DEBOUNCE_CYCLES, SHALL be instantiated four times. Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (bench DEBOUNCE_CYCLES=8)
REQ-025 BTNR high 20 clocks -> request_east_west rises within clocks 8..12 after the edge and stays 1 after release; request_north_south stays 0.
REQ-026 BTNU pulsed high 5 clocks, then low -> no request on either road.
REQ-027 Pending east_west request plus serve_east_west pulse -> request 0 next clock. Serve and a new BTNL press pulse in the same clock -> request stays 1.
REQ-028 BTND held 100 clocks, served at clock 50 -> request clears and does not re-set until release plus a new press.
REQ-029 Request pending, reset_n pulsed low for 1 clock mid-debounce -> all outputs 0 immediately; no spurious request afterwards.
REQ-030 REQUEST_AGING_EN defined, request held, 20 one_second_tick pulses -> age reads 1..15, then stays 15; serve -> age 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants and road enumeration for the request latch
package traffic_pkg;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;
  localparam int AGE_W            = 4;
  localparam int AGE_MAX          = 15;

  typedef enum logic {
    ROAD_EW = 1'b0,
    ROAD_NS = 1'b1
  } road_t;
endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stability counter and press pulse
// for one raw push-button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == CNT_LAST);
  assign o_press    = r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_cnt_done) begin
        // Accept the new level; only a rising acceptance emits a press.
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/traffic_request_latch.sv
// rtl/traffic_request_latch.sv - debounced push-button request latches for two roads;
// optional per-road request aging under REQUEST_AGING_EN.
module traffic_request_latch
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic CLK100MHZ,
  input  logic reset_n,
  input  logic BTNR,
  input  logic BTNL,
  input  logic BTNU,
  input  logic BTND,
  input  logic serve_east_west,
  input  logic serve_north_south,
  output logic request_east_west,
  output logic request_north_south
`ifdef REQUEST_AGING_EN
  ,
  input  logic             one_second_tick,
  output logic [AGE_W-1:0] request_age_ew,
  output logic [AGE_W-1:0] request_age_ns
`endif
);
  logic       w_press_r;
  logic       w_press_l;
  logic       w_press_u;
  logic       w_press_d;
  logic [1:0] w_press;
  logic [1:0] w_serve;
  logic [1:0] r_request;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk(CLK100MHZ), .rst_n(reset_n), .i_btn(BTNR), .o_press(w_press_r));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clk(CLK100MHZ), .rst_n(reset_n), .i_btn(BTNL), .o_press(w_press_l));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
    .clk(CLK100MHZ), .rst_n(reset_n), .i_btn(BTNU), .o_press(w_press_u));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
    .clk(CLK100MHZ), .rst_n(reset_n), .i_btn(BTND), .o_press(w_press_d));

  assign w_press[ROAD_EW] = w_press_r | w_press_l;
  assign w_press[ROAD_NS] = w_press_u | w_press_d;
  assign w_serve[ROAD_EW] = serve_east_west;
  assign w_serve[ROAD_NS] = serve_north_south;

  // Press has priority over serve so a collision keeps the request.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_request <= '0;
    end else begin
      r_request <= w_press | (r_request & ~w_serve);
    end
  end

  assign request_east_west   = r_request[ROAD_EW];
  assign request_north_south = r_request[ROAD_NS];

`ifdef REQUEST_AGING_EN
  logic [AGE_W-1:0] r_age [2];

  for (genvar g = 0; g < 2; g++) begin : g_age
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
        r_age[g] <= '0;
      end else if (!r_request[g] || w_serve[g] || w_press[g]) begin
        // Idle, cleared, fresh or collided requests all restart at zero,
        // except a repeat press on an already-pending request.
        if (r_request[g] && w_press[g] && !w_serve[g]) begin
          r_age[g] <= r_age[g];
        end else begin
          r_age[g] <= '0;
        end
      end else if (one_second_tick && (r_age[g] != AGE_W'(AGE_MAX))) begin
        r_age[g] <= r_age[g] + AGE_W'(1);
      end
    end
  end

  assign request_age_ew = r_age[ROAD_EW];
  assign request_age_ns = r_age[ROAD_NS];
`endif
endmodule

// File: tb/tb_traffic_request_latch.sv
// tb/tb_traffic_request_latch.sv - directed self-checking bench for traffic_request_latch
module tb_traffic_request_latch;
  localparam int DB  = 8;
  // A raw edge driven before clock 1 is accepted at clock DB+2 and the request
  // follows one clock later; the press pulse is live during clock DB+2.
  localparam int LAT = DB + 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic BTNR = 1'b0, BTNL = 1'b0, BTNU = 1'b0, BTND = 1'b0;
  logic serve_ew = 1'b0, serve_ns = 1'b0;
  logic req_ew, req_ns;
`ifdef REQUEST_AGING_EN
  logic       tick = 1'b0;
  logic [3:0] age_ew, age_ns;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  traffic_request_latch #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK100MHZ          (clk),
    .reset_n            (reset_n),
    .BTNR               (BTNR),
    .BTNL               (BTNL),
    .BTNU               (BTNU),
    .BTND               (BTND),
    .serve_east_west    (serve_ew),
    .serve_north_south  (serve_ns),
    .request_east_west  (req_ew),
    .request_north_south(req_ns)
`ifdef REQUEST_AGING_EN
    ,
    .one_second_tick    (tick),
    .request_age_ew     (age_ew),
    .request_age_ns     (age_ns)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Returns the negedge index (1-based) at which the road's request is first 1, or -1.
  task automatic wait_req(input int road, input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((road == 0 ? req_ew : req_ns) === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k, k2, ones;

    clocks(3);
    chk("reset_ew", req_ew, 0);
    chk("reset_ns", req_ns, 0);
    reset_n = 1'b1;
    clocks(2);
    chk("idle_ew", req_ew, 0);

    // Long BTNR press: latency window, hold after release, other road untouched.
    BTNR = 1'b1;
    k = -1; ones = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (req_ew && k < 0) k = i;
      if (req_ns) ones++;
    end
    chk("btnr_seen", int'(k >= 0), 1);
    chk("btnr_latency_window", int'(k >= DB && k <= DB + 4), 1);
    BTNR = 1'b0;
    clocks(20);
    chk("btnr_hold_after_release", req_ew, 1);
    chk("btnr_ns_quiet", ones + int'(req_ns), 0);

    // Serve clears on the next clock.
    serve_ew = 1'b1; @(negedge clk); serve_ew = 1'b0;
    chk("serve_clears_ew", req_ew, 0);

    // Collision: re-arm a pending request, then serve on the same clock as a new press pulse.
    BTNL = 1'b1; wait_req(0, 20, k); BTNL = 1'b0;
    chk("btnl_seen", int'(k >= 0), 1);
    clocks(20);
    BTNL = 1'b1;
    clocks(LAT - 1);
    serve_ew = 1'b1; @(negedge clk); serve_ew = 1'b0;
    chk("collide_set_wins", req_ew, 1);
    clocks(3);
    chk("collide_still_set", req_ew, 1);
    serve_ew = 1'b1; @(negedge clk); serve_ew = 1'b0;
    chk("serve_while_held", req_ew, 0);
    clocks(10);
    chk("held_no_repress", req_ew, 0);
    BTNL = 1'b0;
    clocks(20);

    // Short glitch on BTNU is rejected.
    BTNU = 1'b1; clocks(5); BTNU = 1'b0;
    clocks(25);
    chk("glitch_ns", req_ns, 0);
    chk("glitch_ew", req_ew, 0);

    // Serve with no pending request has no effect.
    serve_ns = 1'b1; @(negedge clk); serve_ns = 1'b0;
    chk("serve_idle_ns", req_ns, 0);

    // BTND held 100 clocks, served at clock 50.
    BTND = 1'b1; ones = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 49) chk("btnd_pending_before_serve", req_ns, 1);
      if (i >= 50 && req_ns) ones++;
      serve_ns = (i == 49);
    end
    chk("btnd_no_reset_while_held", ones, 0);
    BTND = 1'b0;
    clocks(20);
    chk("btnd_release_quiet", req_ns, 0);
    BTND = 1'b1; wait_req(1, 20, k); BTND = 1'b0;
    chk("btnd_new_press", int'(k >= 0), 1);
    serve_ns = 1'b1; @(negedge clk); serve_ns = 1'b0;
    clocks(20);

    // Simultaneous presses on both roads set both requests together.
    BTNR = 1'b1; BTNU = 1'b1;
    k = -1; k2 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (req_ew && k < 0) k = i;
      if (req_ns && k2 < 0) k2 = i;
    end
    chk("simul_both_seen", int'(k >= 0 && k2 >= 0), 1);
    chk("simul_same_clock", k, k2);
    BTNR = 1'b0; BTNU = 1'b0;
    clocks(20);

    // Reset pulse mid-debounce with both requests pending.
    BTNL = 1'b1;
    clocks(4);
    reset_n = 1'b0;
    #1;
    chk("async_reset_ew", req_ew, 0);
    chk("async_reset_ns", req_ns, 0);
    BTNL = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ew || req_ns) ones++;
    end
    chk("no_spurious_after_reset", ones, 0);

    // Button held through reset release produces a press after debounce.
    BTNR = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_req(0, 20, k);
    chk("held_at_release_press", int'(k >= DB && k <= DB + 4), 1);
    BTNR = 1'b0;

`ifdef REQUEST_AGING_EN
    clocks(5);
    chk("age_start", age_ew, 0);
    for (int i = 1; i <= 20; i++) begin
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      chk($sformatf("age_tick%0d", i), age_ew, (i > 15) ? 15 : i);
      @(negedge clk);
    end
    chk("age_ns_idle", age_ns, 0);
    serve_ew = 1'b1; @(negedge clk); serve_ew = 1'b0;
    chk("age_serve_clear", age_ew, 0);
    chk("age_serve_req", req_ew, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule
